div_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider in the EX stage; the responder to the decoded divide request (start_div / signed_div) from the EX-stage divide decode.
- Accepts two operands and a signed/unsigned select, iterates one quotient bit per cycle, and returns {remainder, quotient} with a ready handshake.
- The EX stage feeds result_o[63:32] to HI and result_o[31:0] to LO.
- The EX stage holds start_i high, and stalls the pipeline, until ready_o is seen.

---
 rtl/div_unit.sv | 141 ++++++++++++++
 tb/tb_div_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider returning {remainder, quotient} with a ready handshake.
// Define DIV_ZERO_FLAG_EN to add the div_zero_o output flagging a zero divisor.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
`ifdef DIV_ZERO_FLAG_EN
    output logic                  div_zero_o,
`endif
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {FREE, BY_ZERO, ON, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   dvd_q, dvd_d;   // dividend magnitude, shifts out while quotient shifts in
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic                neg_q_q, neg_q_d;
    logic                neg_r_q, neg_r_d;
    logic [2*DATA_W-1:0] result_d;
    logic                ready_d;
`ifdef DIV_ZERO_FLAG_EN
    logic                dz_d;
`endif

    logic [DATA_W:0]     shifted;
    logic [DATA_W-1:0]   trial;
    logic                ge;

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? (~v + DATA_W'(1)) : v;
    endfunction

    // Difference fits in DATA_W bits whenever the trial subtraction succeeds.
    assign shifted = {rem_q, dvd_q[DATA_W-1]};
    assign ge      = shifted >= {1'b0, dvs_q};
    assign trial   = shifted[DATA_W-1:0] - dvs_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        result_d = result_o;
        ready_d  = ready_o;
`ifdef DIV_ZERO_FLAG_EN
        dz_d     = div_zero_o;
`endif
        case (state_q)
            FREE: begin
                if (start_i && !annul_i) begin
                    dvd_d   = mag(opdata1_i, signed_div_i && opdata1_i[DATA_W-1]);
                    dvs_d   = mag(opdata2_i, signed_div_i && opdata2_i[DATA_W-1]);
                    rem_d   = '0;
                    cnt_d   = '0;
                    neg_q_d = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                    neg_r_d = signed_div_i && opdata1_i[DATA_W-1];
                    state_d = (opdata2_i == '0) ? BY_ZERO : ON;
                end
            end
            BY_ZERO: begin
                result_d = '0;
                ready_d  = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                dz_d     = 1'b1;
`endif
                state_d  = DONE;
            end
            ON: begin
                if (annul_i || !start_i) begin
                    state_d = FREE;
                end else if (cnt_q != CNT_W'(DATA_W)) begin
                    rem_d = ge ? trial : shifted[DATA_W-1:0];
                    dvd_d = {dvd_q[DATA_W-2:0], ge};
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    result_d = {(neg_r_q ? -rem_q : rem_q), (neg_q_q ? -dvd_q : dvd_q)};
                    ready_d  = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                // annul_i is deliberately ignored here; only dropping start_i releases the result
                if (!start_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
`ifdef DIV_ZERO_FLAG_EN
                    dz_d     = 1'b0;
`endif
                    state_d  = FREE;
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FREE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_o <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            result_o <= result_d;
            ready_o  <= ready_d;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_o <= dz_d;
`endif
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed table-driven bench for div_unit plus hand-written abort/reset/hold sequences.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic        start_i, annul_i;
    logic [63:0] result_o;
    logic        ready_o;
`ifdef DIV_ZERO_FLAG_EN
    logic        div_zero_o;
`endif

    int checks = 0;
    int errors = 0;

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
`ifdef DIV_ZERO_FLAG_EN
        .div_zero_o   (div_zero_o),
`endif
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
        logic        dz;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a divide and waits for ready_o; lat = cycle index (accept cycle = 0) of first ready.
    // Operands are scrambled right after acceptance to show they are not re-sampled.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] res, output int lat);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        lat          = 0;
        do begin
            tick();
            lat++;
            if (lat == 1) begin
                opdata1_i    = ~a;
                opdata2_i    = 32'h0;
                signed_div_i = ~sgn;
            end
        end while (!ready_o && lat < 60);
        res = result_o;
    endtask

    task automatic release_chk(input string nm);
        start_i = 1'b0;
        tick();
        chk({nm, "_rel_ready"}, {63'd0, ready_o}, 64'd0);
        chk({nm, "_rel_result"}, result_o, 64'd0);
    endtask

    logic [63:0] res;
    int          lat;
    bit          seen;

    initial begin
        vt[0]  = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 34, 1'b0};
        vt[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, 34, 1'b0};
        vt[2]  = '{1'b0, 32'hFFFFFFF9,   32'd2,        64'h00000001_7FFFFFFC, 34, 1'b0};
        vt[3]  = '{1'b1, 32'h12345678,   32'd0,        64'h0,                 2,  1'b1};
        vt[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 34, 1'b0};
        vt[5]  = '{1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34, 1'b0};
        vt[6]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 34, 1'b0};
        vt[7]  = '{1'b0, 32'd5,          32'd9,        64'h00000005_00000000, 34, 1'b0};
        vt[8]  = '{1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 34, 1'b0};
        vt[9]  = '{1'b0, 32'd0,          32'd0,        64'h0,                 2,  1'b1};
        vt[10] = '{1'b1, 32'h80000000,   32'h80000000, 64'h00000000_00000001, 34, 1'b0};

        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (3) tick();
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        chk("reset_result", result_o, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
        chk("reset_dz", {63'd0, div_zero_o}, 64'd0);
`endif
        rst = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            run_div(vt[i].sgn, vt[i].a, vt[i].b, res, lat);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vt[i].lat));
            chk($sformatf("vec%0d_result", i), res, vt[i].exp);
`ifdef DIV_ZERO_FLAG_EN
            chk($sformatf("vec%0d_dz", i), {63'd0, div_zero_o}, {63'd0, vt[i].dz});
`endif
            release_chk($sformatf("vec%0d", i));
            tick();
        end

        // Abort mid-divide: annul together with start dropping, ready must never rise.
        signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1;
        for (int c = 1; c <= 10; c++) tick();
        annul_i = 1'b1; start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (ready_o) seen = 1'b1;
        end
        chk("abort_no_ready", {63'd0, seen}, 64'd0);
        run_div(1'b0, 32'd9, 32'd3, res, lat);
        chk("after_abort_lat", 64'(lat), 64'd34);
        chk("after_abort_result", res, 64'h00000000_00000003);
        release_chk("after_abort");
        tick();

        // annul with start in FREE must not launch; the divide starts only once annul drops.
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        start_i = 1'b1; annul_i = 1'b1;
        repeat (5) tick();
        annul_i = 1'b0;
        run_div(1'b0, 32'd100, 32'd7, res, lat);
        chk("annul_free_lat", 64'(lat), 64'd34);
        chk("annul_free_result", res, 64'h00000002_0000000E);

        // Hold start 5 cycles past ready, annul in the done state is ignored.
        for (int c = 0; c < 5; c++) begin
            annul_i = (c == 2);
            tick();
            chk($sformatf("hold%0d_ready", c), {63'd0, ready_o}, 64'd1);
            chk($sformatf("hold%0d_result", c), result_o, 64'h00000002_0000000E);
        end
        annul_i = 1'b0;
        release_chk("hold");
        tick();

        // Reset mid-divide.
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_mid_result", result_o, 64'd0);
        rst = 1'b0; start_i = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (ready_o) seen = 1'b1;
        end
        chk("rst_mid_no_ready", {63'd0, seen}, 64'd0);

        // Reset while the result is being held.
        run_div(1'b0, 32'd100, 32'd7, res, lat);
        chk("rst_done_pre", {63'd0, ready_o}, 64'd1);
        rst = 1'b1;
        tick();
        chk("rst_done_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_done_result", result_o, 64'd0);
        rst = 1'b0; start_i = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
